// File: rtl/wimax_chk_pkg.sv
// Shared types and helpers for the WiMAX stream checker: FSM states,
// a 16-bit popcount and a saturating accumulator add.
package wimax_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } chk_state_t;

  localparam int POP_W = 16;

  function automatic logic [4:0] popcount16(input logic [POP_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // The sum is formed one bit wider so it cannot wrap before clamping.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/wimax_chk_symbol_cmp.sv
// Combinational symbol compare: selects golden symbol sym_idx from the
// frame parameter and counts the differing bits against in_data.
module wimax_chk_symbol_cmp
  import wimax_chk_pkg::*;
#(
  parameter int W = 1,
  parameter int FRAME_LEN = 96,
  parameter logic [0:FRAME_LEN*W-1] GOLDEN = '0,
  parameter int IDX_W = $clog2(FRAME_LEN)
) (
  input  logic [IDX_W-1:0] sym_idx,
  input  logic [W-1:0]     in_data,
  output logic [4:0]       bit_errs
);

  logic [W-1:0] golden_sym;
  logic [15:0]  diff;

  // Bit k*W of the ascending golden vector lands on the symbol MSB.
  always_comb begin
    golden_sym = GOLDEN[int'(sym_idx)*W +: W];
    diff       = 16'(in_data ^ golden_sym);
    bit_errs   = popcount16(diff);
  end

endmodule

// File: rtl/wimax_stream_checker.sv
// BIST monitor: compares a valid-qualified symbol stream against a golden
// frame, counting bit errors and frames, and gives a pass/fail verdict.
module wimax_stream_checker
  import wimax_chk_pkg::*;
#(
  parameter int W = 1,
  parameter int FRAME_LEN = 96,
  parameter logic [0:FRAME_LEN*W-1] GOLDEN = '0,
  parameter int NUM_FRAMES = 4,
  parameter int ALIGN_MODE = 0,
  parameter int ERR_W = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [W-1:0]                 in_data,
  input  logic                         in_sof,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         frame_done,
  output logic                         frame_ok,
  output logic                         align_err,
  output logic [ERR_W-1:0]             err_cnt,
  output logic [15:0]                  frame_cnt,
  output logic [$clog2(FRAME_LEN)-1:0] sym_idx,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

  chk_state_t       state_q, state_d;
  logic [IDX_W-1:0] sym_idx_q, sym_idx_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             align_err_q, align_err_d;
  logic             frame_flag_q, frame_flag_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_ok_q, frame_ok_d;

  logic             arm_take, run_take, check_sym, resync;
  logic [IDX_W-1:0] cmp_idx;
  logic             flag_base, sym_err;
  logic [4:0]       bit_errs;
  logic [15:0]      frame_cnt_nxt;

  // A symbol is checked only when start is absent; resync restarts at index 0.
  assign arm_take  = (state_q == ARM) && in_valid && ((ALIGN_MODE == 0) || in_sof);
  assign run_take  = (state_q == RUN) && in_valid;
  assign check_sym = !start && (arm_take || run_take);
  assign resync    = run_take && (ALIGN_MODE != 0) && in_sof && (sym_idx_q != '0);
  assign cmp_idx   = resync ? '0 : sym_idx_q;
  assign flag_base = frame_flag_q && !resync;
  assign sym_err   = (bit_errs != 5'd0);
  assign frame_cnt_nxt = frame_cnt_q + 16'd1;

  wimax_chk_symbol_cmp #(
    .W         (W),
    .FRAME_LEN (FRAME_LEN),
    .GOLDEN    (GOLDEN),
    .IDX_W     (IDX_W)
  ) u_cmp (
    .sym_idx  (cmp_idx),
    .in_data  (in_data),
    .bit_errs (bit_errs)
  );

  always_comb begin
    state_d      = state_q;
    sym_idx_d    = sym_idx_q;
    err_cnt_d    = err_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    align_err_d  = align_err_q;
    frame_flag_d = frame_flag_q;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
    if (start) begin
      state_d      = ARM;
      sym_idx_d    = '0;
      err_cnt_d    = '0;
      frame_cnt_d  = '0;
      align_err_d  = 1'b0;
      frame_flag_d = 1'b0;
    end else if (check_sym) begin
      if (state_q == ARM) begin
        state_d = RUN;
      end
      err_cnt_d = ERR_W'(sat_add(32'(err_cnt_q), 32'(bit_errs), ERR_MAX));
      if (resync) begin
        align_err_d = 1'b1;
      end
      if (cmp_idx == LAST_IDX) begin
        sym_idx_d    = '0;
        frame_done_d = 1'b1;
        frame_ok_d   = !(flag_base || sym_err);
        frame_cnt_d  = frame_cnt_nxt;
        frame_flag_d = 1'b0;
        if ((NUM_FRAMES != 0) && (frame_cnt_nxt == 16'(NUM_FRAMES))) begin
          state_d = DONE;
        end
      end else begin
        sym_idx_d    = cmp_idx + IDX_W'(1);
        frame_flag_d = flag_base || sym_err;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sym_idx_q    <= '0;
      err_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      align_err_q  <= 1'b0;
      frame_flag_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_idx_q    <= sym_idx_d;
      err_cnt_q    <= err_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      align_err_q  <= align_err_d;
      frame_flag_q <= frame_flag_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
    end
  end

  assign busy       = (state_q == ARM) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_cnt_q == '0) && !align_err_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign align_err  = align_err_q;
  assign err_cnt    = err_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign sym_idx    = sym_idx_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_wimax_stream_checker.sv
// Self-checking bench for wimax_stream_checker: four configured instances
// (serial, 2-bit with gaps, 2-bit aligned on sof, 4-bit saturating counter).
module tb_wimax_stream_checker;

  localparam logic [0:95] GOLD_A = 96'h558AC4A53A1724E163AC2BF9;
  localparam logic [0:95] GOLD_B = 96'hC3A50F961E2DB4785A69F00D;

  int errors = 0;
  int checks = 0;

  // clock / reset
  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  logic [0:95] ga, gb;
  logic [1:0]  stim_q[$];
  logic [3:0]  obs_q[$];
  logic [3:0]  exp_q[$];

  // instance A: W=1, 96 symbols, 2 frames, free-running alignment
  logic st_a = 0, v_a = 0, d_a = 0, sof_a = 0;
  logic busy_a, done_a, pass_a, fd_a, fok_a, aerr_a;
  logic [15:0] err_a, fcnt_a;
  logic [6:0]  idx_a;
  logic [1:0]  dbg_a;
  wimax_stream_checker #(.W(1), .FRAME_LEN(96), .GOLDEN(GOLD_A), .NUM_FRAMES(2),
                         .ALIGN_MODE(0), .ERR_W(16)) u_a (
    .clock(clock), .reset(rst), .start(st_a), .in_valid(v_a), .in_data(d_a),
    .in_sof(sof_a), .busy(busy_a), .done(done_a), .pass(pass_a), .frame_done(fd_a),
    .frame_ok(fok_a), .align_err(aerr_a), .err_cnt(err_a), .frame_cnt(fcnt_a),
    .sym_idx(idx_a), .dbg_state(dbg_a));

  // instance B: W=2, 48 symbols, 2 frames
  logic st_b = 0, v_b = 0, sof_b = 0;
  logic [1:0] d_b = 0;
  logic busy_b, done_b, pass_b, fd_b, fok_b, aerr_b;
  logic [15:0] err_b, fcnt_b;
  logic [5:0]  idx_b;
  logic [1:0]  dbg_b;
  wimax_stream_checker #(.W(2), .FRAME_LEN(48), .GOLDEN(GOLD_B), .NUM_FRAMES(2),
                         .ALIGN_MODE(0), .ERR_W(16)) u_b (
    .clock(clock), .reset(rst), .start(st_b), .in_valid(v_b), .in_data(d_b),
    .in_sof(sof_b), .busy(busy_b), .done(done_b), .pass(pass_b), .frame_done(fd_b),
    .frame_ok(fok_b), .align_err(aerr_b), .err_cnt(err_b), .frame_cnt(fcnt_b),
    .sym_idx(idx_b), .dbg_state(dbg_b));

  // instance C: as B but aligned on in_sof
  logic st_c = 0, v_c = 0, sof_c = 0;
  logic [1:0] d_c = 0;
  logic busy_c, done_c, pass_c, fd_c, fok_c, aerr_c;
  logic [15:0] err_c, fcnt_c;
  logic [5:0]  idx_c;
  logic [1:0]  dbg_c;
  wimax_stream_checker #(.W(2), .FRAME_LEN(48), .GOLDEN(GOLD_B), .NUM_FRAMES(2),
                         .ALIGN_MODE(1), .ERR_W(16)) u_c (
    .clock(clock), .reset(rst), .start(st_c), .in_valid(v_c), .in_data(d_c),
    .in_sof(sof_c), .busy(busy_c), .done(done_c), .pass(pass_c), .frame_done(fd_c),
    .frame_ok(fok_c), .align_err(aerr_c), .err_cnt(err_c), .frame_cnt(fcnt_c),
    .sym_idx(idx_c), .dbg_state(dbg_c));

  // instance D: as A with a 4-bit error counter
  logic st_d = 0, v_d = 0, d_d = 0, sof_d = 0;
  logic busy_d, done_d, pass_d, fd_d, fok_d, aerr_d;
  logic [3:0]  err_d;
  logic [15:0] fcnt_d;
  logic [6:0]  idx_d;
  logic [1:0]  dbg_d;
  wimax_stream_checker #(.W(1), .FRAME_LEN(96), .GOLDEN(GOLD_A), .NUM_FRAMES(2),
                         .ALIGN_MODE(0), .ERR_W(4)) u_d (
    .clock(clock), .reset(rst), .start(st_d), .in_valid(v_d), .in_data(d_d),
    .in_sof(sof_d), .busy(busy_d), .done(done_d), .pass(pass_d), .frame_done(fd_d),
    .frame_ok(fok_d), .align_err(aerr_d), .err_cnt(err_d), .frame_cnt(fcnt_d),
    .sym_idx(idx_d), .dbg_state(dbg_d));

  // frame_done monitor: records {instance, frame_ok, done} per pulse
  always @(negedge clock) begin
    if (fd_a) obs_q.push_back({2'd0, fok_a, done_a});
    if (fd_b) obs_q.push_back({2'd1, fok_b, done_b});
    if (fd_c) obs_q.push_back({2'd2, fok_c, done_c});
    if (fd_d) obs_q.push_back({2'd3, fok_d, done_d});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gold(input int id, input int k);
    if (id == 1 || id == 2) return {gb[2*k], gb[2*k+1]};
    return {1'b0, ga[k]};
  endfunction

  // Reference: per-frame bit-error totals from the whole stimulus list.
  function automatic int expect_session(input int id, input int flen, input int nf,
                                        input int err_max);
    int tot;
    int e;
    tot = 0;
    for (int f = 0; f < stim_q.size() / flen; f++) begin
      e = 0;
      for (int k = 0; k < flen; k++) e += $countones(stim_q[f*flen+k] ^ gold(id, k));
      tot += e;
      exp_q.push_back({id[1:0], e == 0, f == nf - 1});
    end
    return (tot > err_max) ? err_max : tot;
  endfunction

  task automatic drive(input int id, input logic [1:0] d, input logic sof);
    case (id)
      0:       begin v_a = 1'b1; d_a = d[0]; end
      1:       begin v_b = 1'b1; d_b = d; end
      2:       begin v_c = 1'b1; d_c = d; sof_c = sof; end
      default: begin v_d = 1'b1; d_d = d[0]; end
    endcase
    @(negedge clock);
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0; v_d = 1'b0; sof_c = 1'b0;
  endtask

  task automatic kick(input int id, input logic with_sym, input logic [1:0] d);
    case (id)
      0:       begin st_a = 1'b1; v_a = with_sym; d_a = d[0]; end
      1:       begin st_b = 1'b1; v_b = with_sym; d_b = d; end
      2:       begin st_c = 1'b1; v_c = with_sym; d_c = d; end
      default: begin st_d = 1'b1; v_d = with_sym; d_d = d[0]; end
    endcase
    @(negedge clock);
    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; st_d = 1'b0;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0; v_d = 1'b0;
  endtask

  task automatic stream(input int id, input int gap_pct, input int from, input int to);
    for (int i = from; i < to; i++) begin
      for (int g = 0; g < 6 && $urandom_range(0, 99) < gap_pct; g++) @(negedge clock);
      drive(id, stim_q[i], 1'b0);
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_frames"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check($sformatf("%s_frame%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic golden_frames(input int id, input int flen, input int n);
    stim_q.delete();
    for (int f = 0; f < n; f++)
      for (int k = 0; k < flen; k++) stim_q.push_back(gold(id, k));
  endtask

  initial begin
    int exp_err;
    ga = GOLD_A;
    gb = GOLD_B;
    repeat (2) @(negedge clock);

    // reset state
    check("rst_flags_a", 32'({busy_a, done_a, pass_a, fd_a, fok_a, aerr_a}), 0);
    check("rst_cnt_a", 32'({err_a, fcnt_a}), 0);
    check("rst_idx_a", 32'({idx_a, dbg_a}), 0);
    check("rst_flags_c", 32'({busy_c, done_c, pass_c, fd_c, fok_c, aerr_c}), 0);
    rst = 1'b1;
    @(negedge clock);
    check("idle_no_start_a", 32'({busy_a, dbg_a}), 0);

    // A: two clean frames, no gaps
    kick(0, 1'b0, 2'd0);
    check("arm_a", 32'({busy_a, dbg_a}), 32'h5);
    golden_frames(0, 96, 2);
    exp_err = expect_session(0, 96, 2, 65535);
    stream(0, 0, 0, 50);
    check("mid_idx_a", 32'(idx_a), 50);
    stream(0, 0, 50, 192);
    @(negedge clock);
    check_frames("clean_a");
    check("clean_done_pass_a", 32'({done_a, pass_a, busy_a}), 32'h6);
    check("clean_err_a", 32'(err_a), 32'(exp_err));
    check("clean_fcnt_a", 32'(fcnt_a), 2);

    // A: start in DONE with a coincident wrong symbol, then flipped bits
    kick(0, 1'b1, {1'b0, ~gold(0, 0)});
    check("restart_err_a", 32'({err_a, idx_a}), 0);
    check("restart_fcnt_a", 32'(fcnt_a), 0);
    check("restart_state_a", 32'({done_a, pass_a, busy_a}), 32'h1);
    golden_frames(0, 96, 2);
    stim_q[5] = ~stim_q[5] & 2'b01;
    stim_q[96+10] = ~stim_q[96+10] & 2'b01;
    stim_q[96+11] = ~stim_q[96+11] & 2'b01;
    exp_err = expect_session(0, 96, 2, 65535);
    stream(0, 0, 0, 192);
    @(negedge clock);
    check_frames("flip_a");
    check("flip_err_a", 32'(err_a), 32'(exp_err));
    check("flip_verdict_a", 32'({done_a, pass_a}), {30'd0, 1'b1, exp_err == 0});

    // A: abort mid-run with start, then a clean session
    kick(0, 1'b0, 2'd0);
    stim_q.delete();
    exp_err = 0;
    for (int k = 0; k < 30; k++) begin
      stim_q.push_back(~gold(0, k) & 2'b01);
      exp_err += $countones(stim_q[k] ^ gold(0, k));
    end
    stream(0, 0, 0, 30);
    check("partial_err_a", 32'(err_a), 32'(exp_err));
    kick(0, 1'b1, {1'b0, ~gold(0, 30)});
    check("abort_clear_a", 32'({err_a, fcnt_a}), 0);
    check("abort_idx_a", 32'({idx_a, busy_a, done_a}), 32'h2);
    golden_frames(0, 96, 2);
    exp_err = expect_session(0, 96, 2, 65535);
    stream(0, 0, 0, 192);
    @(negedge clock);
    check_frames("after_abort_a");
    check("after_abort_pass_a", 32'({done_a, pass_a, err_a}), {14'd0, 2'b11, 16'(exp_err)});

    // B: W=2 clean frames with ~30% idle cycles
    kick(1, 1'b0, 2'd0);
    golden_frames(1, 48, 2);
    exp_err = expect_session(1, 48, 2, 65535);
    stream(1, 30, 0, 30);
    check("gap_idx_b", 32'(idx_b), 30);
    repeat (7) @(negedge clock);
    check("gap_hold_b", 32'({idx_b, err_b}), {10'd0, 6'd30, 16'd0});
    stream(1, 30, 30, 96);
    @(negedge clock);
    check_frames("gap_b");
    check("gap_verdict_b", 32'({done_b, pass_b, fcnt_b}), 32'h30002);

    // B: random symbol corruption with gaps
    kick(1, 1'b0, 2'd0);
    golden_frames(1, 48, 2);
    foreach (stim_q[i]) begin
      if ($urandom_range(0, 99) < 25) stim_q[i] = stim_q[i] ^ 2'($urandom_range(1, 3));
    end
    exp_err = expect_session(1, 48, 2, 65535);
    stream(1, 30, 0, 96);
    @(negedge clock);
    check_frames("rand_b");
    check("rand_err_b", 32'(err_b), 32'(exp_err));
    check("rand_verdict_b", 32'({done_b, pass_b}), {30'd0, 1'b1, exp_err == 0});

    // C: garbage before sof, resync at index 20, then full frames
    kick(2, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) drive(2, 2'($urandom_range(0, 3)), 1'b0);
    check("garbage_c", 32'({err_c, idx_c}), 0);
    check("garbage_state_c", 32'({busy_c, dbg_c}), 32'h5);
    drive(2, gold(2, 0), 1'b1);
    for (int k = 1; k < 20; k++) drive(2, (k == 7) ? ~gold(2, k) : gold(2, k), 1'b0);
    check("pre_resync_c", 32'({idx_c, fcnt_c}), {10'd0, 6'd20, 16'd0});
    drive(2, gold(2, 0), 1'b1);
    check("resync_aerr_c", 32'(aerr_c), 1);
    check("resync_cnt_c", 32'({idx_c, fcnt_c}), {10'd0, 6'd1, 16'd0});
    exp_q.push_back({2'd2, 1'b1, 1'b0});
    exp_q.push_back({2'd2, 1'b1, 1'b1});
    for (int k = 1; k < 48; k++) drive(2, gold(2, k), 1'b0);
    for (int k = 0; k < 48; k++) drive(2, gold(2, k), k == 0);
    @(negedge clock);
    check_frames("align_c");
    check("align_err_cnt_c", 32'(err_c), 2);
    check("align_verdict_c", 32'({done_c, pass_c, aerr_c, fcnt_c}), 32'h50002);

    // D: 4-bit counter saturates, then async reset mid-run
    kick(3, 1'b0, 2'd0);
    stim_q.delete();
    for (int k = 0; k < 40; k++) stim_q.push_back(~gold(3, k) & 2'b01);
    stream(3, 0, 0, 30);
    check("sat_d", 32'(err_d), 15);
    stream(3, 0, 30, 40);
    check("sat_hold_d", 32'({err_d, idx_d}), {21'd0, 4'd15, 7'd40});
    #2 rst = 1'b0;
    #1;
    check("async_rst_flags_d", 32'({busy_d, done_d, pass_d, fd_d, fok_d, aerr_d}), 0);
    check("async_rst_cnt_d", 32'({err_d, fcnt_d, idx_d, dbg_d}), 0);
    repeat (2) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    kick(3, 1'b0, 2'd0);
    golden_frames(3, 96, 2);
    exp_err = expect_session(3, 96, 2, 15);
    stream(3, 0, 0, 192);
    @(negedge clock);
    check_frames("post_rst_d");
    check("post_rst_verdict_d", 32'({done_d, pass_d, err_d, fcnt_d}),
          {10'd0, 2'b11, 4'(exp_err), 16'd2});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
